// File: rtl/spn_cipher_pkg.sv
// Shared types, S-box tables and width-generic helpers for the SPN stream cipher.
// Helpers operate on a MAX_W-wide carrier; callers zero-extend and take the low DATA_W bits.
package spn_cipher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  localparam int MAX_W = 64;
  typedef logic [MAX_W-1:0] wide_t;

  localparam logic [15:0] DEF_SEED = 16'hACE1;
  localparam logic [15:0] DEF_TAPS = 16'hB400;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] SBOX_INV [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  function automatic wide_t width_mask(input int w);
    return {MAX_W{1'b1}} >> (MAX_W - w);
  endfunction

  function automatic wide_t sub_word(input wide_t x, input int w);
    wide_t r;
    r = '0;
    for (int i = 0; i < MAX_W / 4; i++) begin
      if (i < w / 4) r[4*i +: 4] = SBOX[x[4*i +: 4]];
    end
    return r;
  endfunction

  function automatic wide_t inv_sub_word(input wide_t x, input int w);
    wide_t r;
    r = '0;
    for (int i = 0; i < MAX_W / 4; i++) begin
      if (i < w / 4) r[4*i +: 4] = SBOX_INV[x[4*i +: 4]];
    end
    return r;
  endfunction

  // s must lie in [0, w); a zero shift makes the right-shift term vanish.
  function automatic wide_t rotl(input wide_t x, input int s, input int w);
    wide_t m;
    wide_t v;
    m = width_mask(w);
    v = x & m;
    return ((v << s) | (v >> (w - s))) & m;
  endfunction

  function automatic wide_t rotr(input wide_t x, input int s, input int w);
    return rotl(x, (w - s) % w, w);
  endfunction

endpackage

// File: rtl/spn_round.sv
// One combinational SPN round: encrypt is P(S(x ^ k)), decrypt is Sinv(Pinv(x)) ^ k.
module spn_round
  import spn_cipher_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] k_r,
  input  logic              mode,
  output logic [DATA_W-1:0] y
);

  wide_t x_w;
  wide_t k_w;
  wide_t enc_w;
  wide_t dec_w;
  logic  unused_hi;

  always_comb begin
    x_w               = '0;
    k_w               = '0;
    x_w[DATA_W-1:0]   = x;
    k_w[DATA_W-1:0]   = k_r;
    enc_w = rotl(sub_word(x_w ^ k_w, DATA_W), 3 % DATA_W, DATA_W);
    dec_w = inv_sub_word(rotr(x_w, 3 % DATA_W, DATA_W), DATA_W) ^ k_w;
    y     = mode ? dec_w[DATA_W-1:0] : enc_w[DATA_W-1:0];
  end

  assign unused_hi = ^{enc_w, dec_w};

endmodule

// File: rtl/spn_cipher_stream.sv
// Handshaked LFSR-keyed SPN cipher: one word in flight, one round per clock.
// Valid/ready: a transfer happens on any rising edge where valid and ready are both high; valid never drops without a transfer.
module spn_cipher_stream
  import spn_cipher_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                ROUNDS    = 2,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(DEF_TAPS),
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(DEF_SEED)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output state_t            dbg_state
);

  localparam int CNT_W = $clog2(ROUNDS + 1);

  state_t            state;
  state_t            state_nxt;
  logic [LFSR_W-1:0] lfsr;
  logic [DATA_W-1:0] x_q;
  logic [DATA_W-1:0] key_q;
  logic              mode_q;
  logic [CNT_W-1:0]  rnd_q;
  logic [DATA_W-1:0] k_r;
  logic [DATA_W-1:0] round_out;
  logic              in_fire;
  int                r_idx;
  wide_t             key_w;
  wide_t             kr_w;
  logic              unused_hi;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (in_valid) state_nxt = ST_ROUND;
      ST_ROUND: if (rnd_q == CNT_W'(ROUNDS)) state_nxt = ST_OUT;
      ST_OUT:   if (out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE) && !rst;
    busy      = (state != ST_IDLE);
    dbg_state = state;
  end

  assign in_fire = in_valid && in_ready;

  // Decrypt walks the round keys in reverse; the index is parked at 0 on the transfer-to-output edge.
  always_comb begin
    r_idx = 0;
    if (rnd_q < CNT_W'(ROUNDS)) r_idx = mode_q ? (ROUNDS - 1 - int'(rnd_q)) : int'(rnd_q);
    key_w               = '0;
    key_w[DATA_W-1:0]   = key_q;
    kr_w                = rotl(key_w, r_idx % DATA_W, DATA_W);
    k_r                 = kr_w[DATA_W-1:0];
  end

  assign unused_hi = ^kr_w;

  spn_round #(.DATA_W(DATA_W)) u_round (
    .x    (x_q),
    .k_r  (k_r),
    .mode (mode_q),
    .y    (round_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr      <= SEED;
      out_valid <= 1'b0;
      out_data  <= '0;
      rnd_q     <= '0;
      x_q       <= '0;
      key_q     <= '0;
      mode_q    <= 1'b0;
    end else begin
      // A reseed wins over the keystream advance; the accepted word still takes the old key.
      if (seed_load)    lfsr <= (seed == '0) ? SEED : seed;
      else if (in_fire) lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
      case (state)
        ST_IDLE: begin
          if (in_fire) begin
            x_q    <= in_data;
            key_q  <= lfsr[DATA_W-1:0];
            mode_q <= mode;
            rnd_q  <= '0;
          end
        end
        ST_ROUND: begin
          if (rnd_q == CNT_W'(ROUNDS)) begin
            out_data  <= x_q;
            out_valid <= 1'b1;
          end else begin
            x_q   <= round_out;
            rnd_q <= rnd_q + CNT_W'(1);
          end
        end
        ST_OUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spn_cipher_stream.sv
// Directed known-answer bench for the 8-bit default cipher plus a 16-bit encrypt->decrypt round-trip chain.
module tb_spn_cipher_stream;
  import spn_cipher_pkg::*;

  localparam int N_RAND  = 4000;
  localparam int MAX_CYC = 80000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mode, seed_load, in_valid, out_ready;
  logic [15:0] seed;
  logic [7:0]  in_data;
  logic        in_ready, out_valid, busy;
  logic [7:0]  out_data;
  state_t      dbg_state;

  logic        e_in_valid, e_in_ready, e_out_valid, e_busy;
  logic [15:0] e_in_data, e_out_data;
  state_t      e_state;
  logic        d_in_ready, d_out_valid, d_out_ready, d_busy;
  logic [15:0] d_out_data;
  state_t      d_state;

  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  spn_cipher_stream u_dut8 (
    .clk(clk), .rst(rst), .mode(mode), .seed_load(seed_load), .seed(seed),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .dbg_state(dbg_state)
  );

  spn_cipher_stream #(.DATA_W(16), .ROUNDS(4)) u_enc16 (
    .clk(clk), .rst(rst), .mode(1'b0), .seed_load(1'b0), .seed(16'h0000),
    .in_valid(e_in_valid), .in_ready(e_in_ready), .in_data(e_in_data),
    .out_valid(e_out_valid), .out_ready(d_in_ready), .out_data(e_out_data),
    .busy(e_busy), .dbg_state(e_state)
  );

  spn_cipher_stream #(.DATA_W(16), .ROUNDS(4)) u_dec16 (
    .clk(clk), .rst(rst), .mode(1'b1), .seed_load(1'b0), .seed(16'h0000),
    .in_valid(e_out_valid), .in_ready(d_in_ready), .in_data(e_out_data),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
    .busy(d_busy), .dbg_state(d_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_seed(input logic [15:0] sd);
    @(negedge clk);
    seed_load = 1'b1;
    seed      = sd;
    @(negedge clk);
    seed_load = 1'b0;
  endtask

  // Returns #1 after the accepting edge, with mode/in_data scrambled.
  task automatic send(input logic m, input logic [7:0] d, input logic ld, input logic [15:0] sd);
    int guard;
    guard = 0;
    @(negedge clk);
    mode = m; in_data = d; in_valid = 1'b1; seed_load = ld; seed = sd;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("send_wait", 32'(guard), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0; seed_load = 1'b0; mode = ~m; in_data = ~d;
  endtask

  // Counts edges until out_valid, checks data, and completes the handshake if out_ready is high.
  task automatic recv(input string tag, input logic [7:0] exp, input int exp_edges);
    int edges;
    int rdy_hi;
    edges  = 0;
    rdy_hi = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (in_ready) rdy_hi++;
    end while (!out_valid && edges < 50);
    check({tag, "_lat"},   32'(edges), 32'(exp_edges));
    check({tag, "_data"},  32'(out_data), 32'(exp));
    check({tag, "_ready"}, 32'(rdy_hi), 32'd0);
    if (out_ready) begin
      @(posedge clk);
      #1;
      check({tag, "_drop"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin : main
    int stable;
    int seen;
    rst = 1'b1; mode = 1'b0; seed_load = 1'b0; seed = '0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1; e_in_valid = 1'b0; e_in_data = '0; d_out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_in_ready",  32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_state",     32'(dbg_state), 32'(ST_IDLE));
    check("rst_lfsr",      32'(u_dut8.lfsr), 32'h0000ACE1);
    rst = 1'b0;
    #1;
    check("rst_release_ready", 32'(in_ready), 32'd1);

    // Key E1 encrypts 00 to 45; the LFSR steps to E270, so the next word uses key 70 -> 56.
    send(1'b0, 8'h00, 1'b0, 16'h0);
    check("t1_lfsr", 32'(u_dut8.lfsr), 32'h0000E270);
    check("t1_busy", 32'(busy), 32'd1);
    recv("t1", 8'h45, 3);
    send(1'b0, 8'h00, 1'b0, 16'h0);
    recv("t2", 8'h56, 3);

    load_seed(16'hACE1);
    send(1'b1, 8'h45, 1'b0, 16'h0);
    recv("t3_dec", 8'h00, 3);

    // Output stall with a competing word held at the input.
    load_seed(16'hACE1);
    out_ready = 1'b0;
    send(1'b0, 8'h00, 1'b0, 16'h0);
    recv("t4", 8'h45, 3);
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hFF;
    stable = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1 && out_data === 8'h45 && in_ready === 1'b0 && busy === 1'b1) stable++;
    end
    check("t4_stable", 32'(stable), 32'd10);
    check("t4_lfsr_hold", 32'(u_dut8.lfsr), 32'h0000E270);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t4_release_state", 32'(dbg_state), 32'(ST_IDLE));
    check("t4_release_valid", 32'(out_valid), 32'd0);

    load_seed(16'h0000);
    check("t5_zero_seed", 32'(u_dut8.lfsr), 32'h0000ACE1);

    // Reseed on the accepting edge: this word keyed E1 -> 45, next keyed 34 -> 87.
    send(1'b0, 8'h00, 1'b1, 16'h1234);
    check("t6_lfsr_loaded", 32'(u_dut8.lfsr), 32'h00001234);
    recv("t6_old_key", 8'h45, 3);
    send(1'b0, 8'h00, 1'b0, 16'h0);
    recv("t6_new_key", 8'h87, 3);

    // Reseed one edge into ROUND; two edges of latency remain when recv starts.
    load_seed(16'hACE1);
    send(1'b0, 8'h00, 1'b0, 16'h0);
    @(negedge clk);
    seed_load = 1'b1; seed = 16'h1234;
    @(negedge clk);
    seed_load = 1'b0;
    recv("t7_midround", 8'h45, 2);
    check("t7_lfsr", 32'(u_dut8.lfsr), 32'h00001234);

    send(1'b0, 8'h00, 1'b0, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t8_rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t8_ready_after", 32'(in_ready), 32'd1);
    check("t8_lfsr", 32'(u_dut8.lfsr), 32'h0000ACE1);
    check("t8_state", 32'(dbg_state), 32'(ST_IDLE));
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("t8_no_out", 32'(seen), 32'd0);

    fork
      begin : drv
        for (int n = 0; n < N_RAND; n++) begin
          logic [15:0] w;
          int g;
          w = 16'($urandom_range(0, 65535));
          repeat ($urandom_range(0, 2)) @(negedge clk);
          @(negedge clk);
          e_in_valid = 1'b1;
          e_in_data  = w;
          g = 0;
          while (!e_in_ready && g < 40) begin
            @(negedge clk);
            g++;
          end
          @(posedge clk);
          exp_q.push_back(w);
          #1;
          e_in_valid = 1'b0;
        end
      end
      begin : mon
        int got_n;
        int cyc;
        got_n = 0;
        cyc   = 0;
        while (got_n < N_RAND && cyc < MAX_CYC) begin
          @(negedge clk);
          cyc++;
          d_out_ready = ($urandom_range(0, 3) != 0);
          if (d_out_valid && d_out_ready) begin
            check("rand_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("rand_roundtrip", 32'(d_out_data), 32'(exp_q.pop_front()));
            got_n++;
          end
        end
        check("rand_count", 32'(got_n), 32'(N_RAND));
      end
    join
    check("rand_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
